// File: rtl/apb_gpio_ng_pkg.sv
// apb_gpio_ng shared definitions
// register offsets, CTRL bits and address decode
package apb_gpio_ng_pkg;

  localparam logic [31:0] OFS_IN    = 32'h00;
  localparam logic [31:0] OFS_OUT   = 32'h04;
  localparam logic [31:0] OFS_OE    = 32'h08;
  localparam logic [31:0] OFS_INTE  = 32'h0C;
  localparam logic [31:0] OFS_PTRIG = 32'h10;
  localparam logic [31:0] OFS_NTRIG = 32'h14;
  localparam logic [31:0] OFS_INTS  = 32'h18;
  localparam logic [31:0] OFS_CTRL  = 32'h1C;
  localparam logic [31:0] OFS_DBNC  = 32'h20;

  localparam int CTRL_IE = 0;

  typedef enum logic [3:0] {
    SEL_IN,
    SEL_OUT,
    SEL_OE,
    SEL_INTE,
    SEL_PTRIG,
    SEL_NTRIG,
    SEL_INTS,
    SEL_CTRL,
    SEL_DBNC,
    SEL_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode(
    input logic [31:0] a
  );
    reg_sel_e s;
    unique case (1'b1)
      (a == OFS_IN):    s = SEL_IN;
      (a == OFS_OUT):   s = SEL_OUT;
      (a == OFS_OE):    s = SEL_OE;
      (a == OFS_INTE):  s = SEL_INTE;
      (a == OFS_PTRIG): s = SEL_PTRIG;
      (a == OFS_NTRIG): s = SEL_NTRIG;
      (a == OFS_INTS):  s = SEL_INTS;
      (a == OFS_CTRL):  s = SEL_CTRL;
      (a == OFS_DBNC):  s = SEL_DBNC;
      default:          s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/apb_gpio_ng_dbnc_cell.sv
// gpio_dbnc_cell: one pin of the input path
// 2-flop sync, debounce filter, edge detect
module gpio_dbnc_cell #(
  parameter int DBW = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           pad_i,
  input  logic [DBW-1:0] limit_i,
  output logic           filt_o,
  output logic           rise_o,
  output logic           fall_o
);

  logic           sync1_q;
  logic           sync2_q;
  logic           filt_q;
  logic           filt_d;
  logic           fdly_q;
  logic [DBW-1:0] cnt_q;
  logic [DBW-1:0] cnt_d;

  // filt flips once sync2 has disagreed for limit+1 cycles
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q >= limit_i) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + DBW'(1);
    end
  end

  // sync chain, filter state and delayed filt
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      fdly_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      fdly_q  <= filt_q;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;
  assign rise_o = filt_q & ~fdly_q;
  assign fall_o = ~filt_q & fdly_q;

endmodule

// File: rtl/apb_gpio_ng.sv
// apb_gpio_ng: APB GPIO slave top
// register file, decode, interrupt status, IRQ
module apb_gpio_ng
  import apb_gpio_ng_pkg::*;
#(
  parameter int NGPIO = 32,
  parameter int DBW   = 8,
  parameter int AW    = 8
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [31:0]      PADDR,
  input  logic [31:0]      PWDATA,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  output logic             PSLVERR,
  input  logic [NGPIO-1:0] gpio_i,
  output logic [NGPIO-1:0] gpio_o,
  output logic [NGPIO-1:0] gpio_oe,
  output logic             IRQ
);

  localparam logic [31:0] AMASK =
    (AW >= 32) ? 32'hFFFF_FFFF
               : ((32'd1 << AW) - 32'd1);

  logic [NGPIO-1:0] out_q,   out_d;
  logic [NGPIO-1:0] oe_q,    oe_d;
  logic [NGPIO-1:0] inte_q,  inte_d;
  logic [NGPIO-1:0] ptrig_q, ptrig_d;
  logic [NGPIO-1:0] ntrig_q, ntrig_d;
  logic [NGPIO-1:0] ints_q,  ints_d;
  logic             ctrl_q,  ctrl_d;
  logic [DBW-1:0]   dbnc_q,  dbnc_d;
  logic             irq_q,   irq_d;

  logic [NGPIO-1:0] filt;
  logic [NGPIO-1:0] rise;
  logic [NGPIO-1:0] fall;
  logic [NGPIO-1:0] ev_set;
  logic [NGPIO-1:0] ev_clr;
  logic [31:0]      rdata;
  logic             wr_en;
  logic             rd_en;
  reg_sel_e         sel;

  assign sel   = decode(PADDR & AMASK);
  assign wr_en = PSEL & PENABLE & PWRITE;
  assign rd_en = PSEL & PENABLE & ~PWRITE;

  for (genvar g = 0; g < NGPIO; g++) begin : g_pin
    gpio_dbnc_cell #(
      .DBW(DBW)
    ) u_cell (
      .clk_i  (PCLK),
      .rst_ni (PRESETn),
      .pad_i  (gpio_i[g]),
      .limit_i(dbnc_q),
      .filt_o (filt[g]),
      .rise_o (rise[g]),
      .fall_o (fall[g])
    );
  end

  assign ev_set = inte_q
                & ((rise & ptrig_q)
                 | (fall & ntrig_q));

  // register writes; a new event beats a same-cycle clear
  always_comb begin
    out_d   = out_q;
    oe_d    = oe_q;
    inte_d  = inte_q;
    ptrig_d = ptrig_q;
    ntrig_d = ntrig_q;
    ctrl_d  = ctrl_q;
    dbnc_d  = dbnc_q;
    ev_clr  = '0;
    if (wr_en) begin
      unique case (sel)
        SEL_OUT:   out_d   = PWDATA[NGPIO-1:0];
        SEL_OE:    oe_d    = PWDATA[NGPIO-1:0];
        SEL_INTE:  inte_d  = PWDATA[NGPIO-1:0];
        SEL_PTRIG: ptrig_d = PWDATA[NGPIO-1:0];
        SEL_NTRIG: ntrig_d = PWDATA[NGPIO-1:0];
        SEL_INTS:  ev_clr  = PWDATA[NGPIO-1:0];
        SEL_CTRL:  ctrl_d  = PWDATA[CTRL_IE];
        SEL_DBNC:  dbnc_d  = PWDATA[DBW-1:0];
        default:   ;
      endcase
    end
    ints_d = (ints_q & ~ev_clr) | ev_set;
    irq_d  = ctrl_q & (|ints_q);
  end

  // register state
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      out_q   <= '0;
      oe_q    <= '0;
      inte_q  <= '0;
      ptrig_q <= '0;
      ntrig_q <= '0;
      ints_q  <= '0;
      ctrl_q  <= 1'b0;
      dbnc_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      oe_q    <= oe_d;
      inte_q  <= inte_d;
      ptrig_q <= ptrig_d;
      ntrig_q <= ntrig_d;
      ints_q  <= ints_d;
      ctrl_q  <= ctrl_d;
      dbnc_q  <= dbnc_d;
      irq_q   <= irq_d;
    end
  end

  // read mux, zero-extended to the bus width
  always_comb begin
    rdata = '0;
    unique case (sel)
      SEL_IN:    rdata[NGPIO-1:0] = filt;
      SEL_OUT:   rdata[NGPIO-1:0] = out_q;
      SEL_OE:    rdata[NGPIO-1:0] = oe_q;
      SEL_INTE:  rdata[NGPIO-1:0] = inte_q;
      SEL_PTRIG: rdata[NGPIO-1:0] = ptrig_q;
      SEL_NTRIG: rdata[NGPIO-1:0] = ntrig_q;
      SEL_INTS:  rdata[NGPIO-1:0] = ints_q;
      SEL_CTRL:  rdata[CTRL_IE]   = ctrl_q;
      SEL_DBNC:  rdata[DBW-1:0]   = dbnc_q;
      default:   ;
    endcase
  end

  assign PRDATA  = (PRESETn & rd_en) ? rdata : '0;
  assign PSLVERR = PRESETn & PSEL & PENABLE
                 & (sel == SEL_NONE);
  assign PREADY  = 1'b1;
  assign gpio_o  = out_q;
  assign gpio_oe = oe_q;
  assign IRQ     = irq_q;

endmodule

// File: tb/tb_apb_gpio_ng.sv
// tb_apb_gpio_ng: directed bench
// full-width and NGPIO=8 instances
module tb_apb_gpio_ng;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PSEL8 = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] gpio_i = '0;
  logic [7:0]  gpio_i8 = '0;

  logic [31:0] prdata, prdata8;
  logic        pready, pready8;
  logic        pslverr, pslverr8;
  logic        irq, irq8;
  logic [31:0] gpio_o, gpio_oe;
  logic [7:0]  gpio_o8, gpio_oe8;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_gpio_ng u_dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PRDATA (prdata),
    .PREADY (pready),
    .PSLVERR(pslverr),
    .gpio_i (gpio_i),
    .gpio_o (gpio_o),
    .gpio_oe(gpio_oe),
    .IRQ    (irq)
  );

  apb_gpio_ng #(
    .NGPIO(8)
  ) u_dut8 (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PSEL   (PSEL8),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PRDATA (prdata8),
    .PREADY (pready8),
    .PSLVERR(pslverr8),
    .gpio_i (gpio_i8),
    .gpio_o (gpio_o8),
    .gpio_oe(gpio_oe8),
    .IRQ    (irq8)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic wr(
    input bit          d8,
    input logic [31:0] a,
    input logic [31:0] d
  );
    @(posedge PCLK); #1;
    PSEL = !d8; PSEL8 = d8;
    PWRITE = 1'b1; PADDR = a;
    PWDATA = d; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PSEL8 = 1'b0;
    PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic rd(
    input  bit          d8,
    input  logic [31:0] a,
    output logic [31:0] d,
    output logic        e
  );
    @(posedge PCLK); #1;
    PSEL = !d8; PSEL8 = d8;
    PWRITE = 1'b0; PADDR = a;
    PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    d = d8 ? prdata8 : prdata;
    e = d8 ? pslverr8 : pslverr;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PSEL8 = 1'b0;
    PENABLE = 1'b0;
  endtask

  task automatic park(input logic [31:0] a);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PWRITE = 1'b0;
    PADDR = a; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
  endtask

  task automatic unpark();
    PSEL = 1'b0;
    PENABLE = 1'b0;
  endtask

  logic [31:0] d;
  logic        e;
  logic        seen;
  logic [31:0] ofs [9] = '{
    32'h00, 32'h04, 32'h08,
    32'h0C, 32'h10, 32'h14,
    32'h18, 32'h1C, 32'h20
  };

  initial begin
    PRESETn = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    chk("rst_irq", {31'd0, irq}, 0);
    chk("rst_oe", gpio_oe, 0);
    chk("rst_out", gpio_o, 0);
    chk("rst_pready", {31'd0, pready}, 1);
    for (int i = 0; i < 9; i++) begin
      rd(0, ofs[i], d, e);
      chk($sformatf("rst_reg%0h", ofs[i]), d, 0);
    end

    wr(0, 32'h04, 32'haaaa_ffff);
    chk("gpio_o", gpio_o, 32'haaaa_ffff);
    wr(0, 32'h08, 32'hffff_ffff);
    chk("gpio_oe", gpio_oe, 32'hffff_ffff);
    rd(0, 32'h04, d, e);
    chk("rd_out", d, 32'haaaa_ffff);
    chk("rd_out_err", {31'd0, e}, 0);
    rd(0, 32'h08, d, e);
    chk("rd_oe", d, 32'hffff_ffff);

    wr(0, 32'h20, 32'd4);
    rd(0, 32'h20, d, e);
    chk("rd_dbnc", d, 4);

    park(32'h00);
    @(posedge PCLK); #1 gpio_i[0] = 1'b1;
    seen = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge PCLK); #1;
      seen |= prdata[0];
      if (k == 3) gpio_i[0] = 1'b0;
    end
    chk("dbnc_short", {31'd0, seen}, 0);

    @(posedge PCLK); #1 gpio_i[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge PCLK); #1;
      if (k == 6)
        chk("dbnc_c6", {31'd0, prdata[0]}, 0);
      if (k == 7)
        chk("dbnc_c7", {31'd0, prdata[0]}, 1);
      if (k == 10) gpio_i[0] = 1'b0;
    end
    repeat (10) @(posedge PCLK);
    #1 chk("dbnc_fall", prdata, 0);
    unpark();

    wr(0, 32'h20, 32'd0);
    wr(0, 32'h0C, 32'h20);
    wr(0, 32'h10, 32'h20);
    wr(0, 32'h14, 32'h20);
    wr(0, 32'h1C, 32'h1);
    park(32'h18);
    @(posedge PCLK); #1 gpio_i[5] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge PCLK); #1;
      if (k == 3) chk("ints_c3", prdata, 0);
      if (k == 4) begin
        chk("ints_c4", prdata, 32'h20);
        chk("irq_c4", {31'd0, irq}, 0);
      end
      if (k == 5)
        chk("irq_c5", {31'd0, irq}, 1);
    end
    gpio_i[5] = 1'b0;
    repeat (6) @(posedge PCLK);
    #1 chk("ints_fall", prdata, 32'h20);
    unpark();

    wr(0, 32'h18, 32'h20);
    chk("irq_hold", {31'd0, irq}, 1);
    @(posedge PCLK); #1;
    chk("irq_drop", {31'd0, irq}, 0);
    rd(0, 32'h18, d, e);
    chk("ints_clr", d, 0);

    @(posedge PCLK); #1 gpio_i[5] = 1'b1;
    repeat (6) @(posedge PCLK);
    #1 chk("irq_rise2", {31'd0, irq}, 1);
    @(posedge PCLK); #1 gpio_i[5] = 1'b0;
    @(posedge PCLK);
    wr(0, 32'h18, 32'h20);
    chk("race_irq", {31'd0, irq}, 1);
    rd(0, 32'h18, d, e);
    chk("race_ints", d, 32'h20);
    chk("race_irq2", {31'd0, irq}, 1);
    wr(0, 32'h18, 32'h20);
    rd(0, 32'h18, d, e);
    chk("clr2", d, 0);

    wr(0, 32'h0C, 32'h0);
    @(posedge PCLK); #1 gpio_i[5] = 1'b1;
    repeat (6) @(posedge PCLK);
    rd(0, 32'h18, d, e);
    chk("inte_off", d, 0);

    rd(0, 32'h40, d, e);
    chk("bad_data", d, 0);
    chk("bad_err", {31'd0, e}, 1);
    rd(0, 32'h24, d, e);
    chk("bad24_err", {31'd0, e}, 1);

    wr(1, 32'h04, 32'hffff_ffff);
    rd(1, 32'h04, d, e);
    chk("n8_out", d, 32'h0000_00ff);
    chk("n8_pin", {24'd0, gpio_o8}, 32'hff);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
